// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the packed-BCD to binary converter: state
// encodings, digit limits and the reverse double-dabble correction constants.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        BCD_ST_IDLE  = 2'd0,
        BCD_ST_SHIFT = 2'd1,
        BCD_ST_DONE  = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'h9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'h8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'h3;

    // A nibble above 9 is not a decimal digit.
    function automatic logic bcd_digit_bad(input logic [3:0] digit);
        return digit > BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake and data bus of the BCD to binary converter.
// The requester (microcode side) is the master, the converter the slave.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// Per-digit corrector for reverse double-dabble: after a right shift a digit
// that reached 8 or more received a carried-in half-ten and is pulled back by 3.
module bcd_digit_adj
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    logic w_over;

    assign w_over  = (i_digit >= BCD_ADJ_THRESH);
    assign o_digit = w_over ? (i_digit - BCD_ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one
// result bit per clock. Operands with a non-decimal digit skip the shift
// sequence and report err with a zero result.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// SHIFT | one shift/correct step per cycle, busy high
// DONE  | single cycle, done high, bin_out/err valid
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    bcd_to_bin_seq_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    bcd_state_e    r_state;
    logic [W-1:0]  r_bcd;
    logic [W-1:0]  r_bin;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [W-1:0]  r_bin_out;

    logic [W-1:0]      w_bcd_shift;
    logic [W-1:0]      w_bcd_adj;
    logic [W-1:0]      w_bin_shift;
    logic [DIGITS-1:0] w_nib_bad;
    logic              w_any_bad;

    // The {bcd, bin} pair shifts right as one register; bcd LSB feeds bin MSB.
    assign w_bcd_shift = {1'b0, r_bcd[W-1:1]};
    assign w_bin_shift = {r_bcd[0], r_bin[W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (w_bcd_shift[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
        assign w_nib_bad[g] = bcd_digit_bad(bus.bcd_in[4*g +: 4]);
    end

    assign w_any_bad = |w_nib_bad;

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= BCD_ST_IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bin_out <= '0;
        end else begin
            case (r_state)
                BCD_ST_IDLE: begin
                    if (bus.start) begin
                        r_bcd <= bus.bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        if (w_any_bad) begin
                            // Result and flag are loaded on entry so they are
                            // valid for the whole DONE cycle.
                            r_state   <= BCD_ST_DONE;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            r_bin_out <= '0;
                        end else begin
                            r_state <= BCD_ST_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                BCD_ST_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_shift;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state   <= BCD_ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        r_bin_out <= w_bin_shift;
                    end
                end
                BCD_ST_DONE: begin
                    r_state <= BCD_ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= BCD_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.bin_out = r_bin_out;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases with literal results,
// randomized traffic against a behavioural timeline model, and a DIGITS=2 copy.
module tb_bcd_to_bin_seq;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_bin_seq_if #(.DIGITS(4)) bus4 ();
    bcd_to_bin_seq_if #(.DIGITS(2)) bus2 ();

    bcd_to_bin_seq #(.DIGITS(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));
    bcd_to_bin_seq #(.DIGITS(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal value of a packed-BCD word, plus whether any nibble is not a digit.
    function automatic void bcd_value(input logic [15:0] v, input int digits,
                                      output int val, output bit bad);
        val = 0;
        bad = 0;
        for (int i = digits - 1; i >= 0; i--) begin
            int d;
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
    endfunction

    // Behavioural timeline for the DIGITS=4 instance.
    bit          e_busy, e_done, e_err;
    logic [15:0] e_bin;
    int          m_left;
    int          m_val;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_busy = 0; e_done = 0; e_err = 0; e_bin = '0; m_left = 0; m_val = 0;
        end else if (e_done) begin
            e_done = 0;
        end else if (e_busy) begin
            m_left--;
            if (m_left == 0) begin
                e_busy = 0;
                e_done = 1;
                e_err  = 0;
                e_bin  = 16'(m_val);
            end
        end else if (bus4.start) begin
            int v; bit b;
            bcd_value(bus4.bcd_in, 4, v, b);
            if (b) begin
                e_done = 1; e_err = 1; e_bin = '0;
            end else begin
                e_busy = 1; m_left = 16; m_val = v;
            end
        end
    end

    // Every-cycle comparison; result/flag only while they are defined to hold.
    always @(negedge clk) begin
        chk("busy", longint'(bus4.busy), longint'(e_busy));
        chk("done", longint'(bus4.done), longint'(e_done));
        if (!e_busy) begin
            chk("bin_out", longint'(bus4.bin_out), longint'(e_bin));
            chk("err", longint'(bus4.err), longint'(e_err));
        end
        if (bus2.busy && bus2.done) chk("d2_busy_done_excl", 1, 0);
    end

    task automatic run4(input logic [15:0] v, output logic [15:0] bin, output logic e,
                        output int lat, output bit busy_seen);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.bcd_in = v;
        lat = 0; busy_seen = 0; bin = '0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus4.start = 1'b0;
                bus4.bcd_in = 16'($urandom);
            end
            if (bus4.busy) busy_seen = 1;
            if (bus4.done) begin
                lat = i; bin = bus4.bin_out; e = bus4.err;
                break;
            end
        end
    endtask

    task automatic run2(input logic [7:0] v, output logic [7:0] bin, output logic e,
                        output int lat);
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.bcd_in = v;
        lat = 0; bin = '0; e = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus2.start = 1'b0;
                bus2.bcd_in = 8'($urandom);
            end
            if (bus2.done) begin
                lat = i; bin = bus2.bin_out; e = bus2.err;
                break;
            end
        end
    endtask

    task automatic idle4(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] b16;
        logic [7:0]  b8;
        logic        e;
        int          lat;
        bit          bs;
        int          t_done[$];
        logic [15:0] r_done[$];

        reset_n = 1'b0;
        bus4.start = 1'b0; bus4.bcd_in = '0;
        bus2.start = 1'b0; bus2.bcd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(bus4.busy), 0);
        chk("rst_done", longint'(bus4.done), 0);
        chk("rst_bin", longint'(bus4.bin_out), 0);
        chk("rst_err", longint'(bus4.err), 0);
        #2 reset_n = 1'b1;
        idle4(2);

        // Directed conversions with hand-computed results.
        run4(16'h1234, b16, e, lat, bs);
        chk("1234_bin", b16, 16'h04D2); chk("1234_err", e, 0); chk("1234_lat", lat, 17);
        idle4(1);
        run4(16'h9999, b16, e, lat, bs);
        chk("9999_bin", b16, 16'h270F); chk("9999_err", e, 0);
        idle4(1);
        run4(16'h0000, b16, e, lat, bs);
        chk("0000_bin", b16, 16'h0000); chk("0000_lat", lat, 17);
        idle4(1);
        run4(16'h12A4, b16, e, lat, bs);
        chk("12A4_lat", lat, 1); chk("12A4_err", e, 1);
        chk("12A4_bin", b16, 0); chk("12A4_nobusy", bs, 0);
        idle4(1);
        run4(16'h0042, b16, e, lat, bs);
        chk("0042_bin", b16, 16'h002A); chk("0042_err", e, 0);
        idle4(2);

        // start held high while the operand changes every cycle.
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (bus4.done) begin
                t_done.push_back(i);
                r_done.push_back(bus4.bin_out);
            end
            bus4.start = (i < 36);
            bus4.bcd_in = (i == 0) ? 16'h0010 : (i == 18) ? 16'h0099 : 16'($urandom);
        end
        bus4.start = 1'b0;
        chk("b2b_count", t_done.size(), 2);
        if (t_done.size() == 2) begin
            chk("b2b_first_t", t_done[0], 17);
            chk("b2b_spacing", t_done[1] - t_done[0], 18);
            chk("b2b_first", r_done[0], 16'h000A);
            chk("b2b_second", r_done[1], 16'h0063);
        end
        idle4(2);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bus4.start = 1'b1; bus4.bcd_in = 16'h5678;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", longint'(bus4.busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", longint'(bus4.busy), 0);
        chk("mid_rst_done", longint'(bus4.done), 0);
        chk("mid_rst_err", longint'(bus4.err), 0);
        chk("mid_rst_bin", longint'(bus4.bin_out), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        bs = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus4.done) bs = 1;
        end
        chk("no_done_after_rst", bs, 0);
        run4(16'h0001, b16, e, lat, bs);
        chk("0001_bin", b16, 16'h0001);
        idle4(1);

        // Narrow instance.
        run2(8'h99, b8, e, lat);
        chk("d2_99_lat", lat, 9); chk("d2_99_bin", b8, 8'h63); chk("d2_99_err", e, 0);
        idle4(1);
        run2(8'h9F, b8, e, lat);
        chk("d2_9F_lat", lat, 1); chk("d2_9F_err", e, 1); chk("d2_9F_bin", b8, 0);
        idle4(1);

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus4.start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus4.bcd_in = 16'($urandom);
            end else begin
                logic [15:0] v;
                v = '0;
                for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
                bus4.bcd_in = v;
            end
        end
        bus4.start = 1'b0;
        idle4(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
